// File: rtl/if_id_skid_stage_if.sv
// if_id_skid_stage_if: fetch-side and decode-side handshake bundle for the IF/ID skid stage.
interface if_id_skid_stage_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, occupancy, stall_cnt, flush_cnt
  );
  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, occupancy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF/ID register with two-entry skid buffer, flush-to-NOP and saturating stall/flush counters.
module if_id_skid_stage #(
  parameter int                 ADDR_W    = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
  parameter int                 CNT_W     = 16
) (
  input logic              clk,
  input logic              reset,
  if_id_skid_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t             r_state;
  logic [ADDR_W-1:0]  r_main_pc, r_skid_pc;
  logic [INSTR_W-1:0] r_main_instr, r_skid_instr;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;
  logic               w_accept, w_take;
  assign bus.in_ready  = (r_state != FULL) & ~bus.flush;
  assign bus.out_valid = (r_state != EMPTY);
  assign bus.out_pc    = r_main_pc;
  assign bus.out_instr = r_main_instr;
  assign bus.occupancy = r_state;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_take   = bus.out_valid & bus.out_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= EMPTY;
      r_main_pc    <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (bus.out_valid & ~bus.out_ready & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bus.flush & ~&r_flush_cnt) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      // a take in the flush cycle needs no extra work: the whole buffer is dropped anyway
      if (bus.flush) begin
        r_state      <= EMPTY;
        r_main_pc    <= '0;
        r_main_instr <= NOP_INSTR;
        r_skid_pc    <= '0;
        r_skid_instr <= '0;
      end else begin
        case (r_state)
          EMPTY: if (w_accept) begin
            r_state      <= ONE;
            r_main_pc    <= bus.in_pc;
            r_main_instr <= bus.in_instr;
          end
          ONE: if (w_accept & w_take) begin
            r_main_pc    <= bus.in_pc;
            r_main_instr <= bus.in_instr;
          end else if (w_accept) begin
            r_state      <= FULL;
            r_skid_pc    <= bus.in_pc;
            r_skid_instr <= bus.in_instr;
          end else if (w_take) begin
            r_state      <= EMPTY;
            r_main_pc    <= '0;
            r_main_instr <= NOP_INSTR;
          end
          FULL: if (w_take) begin
            r_state      <= ONE;
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb_if_id_skid_stage: scoreboard bench for the IF/ID skid stage, plus a narrow-counter instance for saturation.
module tb_if_id_skid_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t q[$];
  logic [15:0] e_stall = 0;
  logic [15:0] e_flush = 0;

  always #5 clk = ~clk;

  if_id_skid_stage_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(16)) b ();
  if_id_skid_stage_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(4))  bs ();

  if_id_skid_stage #(.ADDR_W(64), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(16)) u_dut (
    .clk(clk), .reset(rst_n), .bus(b)
  );
  if_id_skid_stage #(.ADDR_W(64), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(4)) u_sat (
    .clk(clk), .reset(rst_n), .bus(bs)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                      input logic fl, input logic rdy);
    int n0;
    bit acc;
    ent_t e;
    @(negedge clk);
    b.in_valid = v; b.in_pc = pc; b.in_instr = ins; b.flush = fl; b.out_ready = rdy;
    #1;
    n0 = q.size();
    acc = v && !fl && n0 < 2;
    chk("occupancy", 64'(b.occupancy), 64'(n0));
    chk("out_valid", 64'(b.out_valid), 64'(n0 != 0));
    chk("in_ready", 64'(b.in_ready), 64'(n0 < 2 && !fl));
    chk("stall_cnt", 64'(b.stall_cnt), 64'(e_stall));
    chk("flush_cnt", 64'(b.flush_cnt), 64'(e_flush));
    if (n0 == 0) begin
      chk("empty_pc", b.out_pc, 64'h0);
      chk("empty_instr", 64'(b.out_instr), 64'(NOP));
    end else begin
      chk("head_pc", b.out_pc, q[0].pc);
      chk("head_instr", 64'(b.out_instr), 64'(q[0].ins));
      if (rdy) e = q.pop_front();
      if (!rdy && e_stall != 16'hffff) e_stall++;
    end
    if (fl && e_flush != 16'hffff) e_flush++;
    if (fl) q.delete();
    else if (acc) begin
      e.pc = pc; e.ins = ins;
      q.push_back(e);
    end
  endtask

  initial begin
    b.in_valid = 0; b.in_pc = 0; b.in_instr = 0; b.flush = 0; b.out_ready = 0;
    bs.in_valid = 0; bs.in_pc = 0; bs.in_instr = 0; bs.flush = 0; bs.out_ready = 0;
    #12;
    chk("rst_out_valid", 64'(b.out_valid), 64'h0);
    chk("rst_occupancy", 64'(b.occupancy), 64'h0);
    chk("rst_in_ready", 64'(b.in_ready), 64'h1);
    chk("rst_out_pc", b.out_pc, 64'h0);
    chk("rst_out_instr", 64'(b.out_instr), 64'(NOP));
    chk("rst_stall_cnt", 64'(b.stall_cnt), 64'h0);
    chk("rst_flush_cnt", 64'(b.flush_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1;
    // streaming at full rate
    step(1, 64'h0, 32'hA, 0, 1);
    step(1, 64'h4, 32'hB, 0, 1);
    step(1, 64'h8, 32'hC, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // back-pressure fill, third beat held off, then drain
    step(1, 64'h100, 32'h100, 0, 0);
    step(1, 64'h104, 32'h104, 0, 0);
    step(1, 64'h108, 32'h108, 0, 0);
    step(1, 64'h108, 32'h108, 0, 0);
    step(1, 64'h108, 32'h108, 0, 1);
    step(1, 64'h108, 32'h108, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // flush while full with a beat offered
    step(1, 64'h200, 32'h200, 0, 0);
    step(1, 64'h204, 32'h204, 0, 0);
    step(1, 64'h208, 32'h208, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 64'h20c, 32'h20c, 1, 1);
    step(0, 0, 0, 0, 1);
    // randomised traffic
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 64'(i) << 2, $urandom, $urandom_range(0, 15) == 0,
           1'($urandom_range(0, 2) != 0));
    // asynchronous reset with two entries held
    step(1, 64'h300, 32'h300, 0, 0);
    step(1, 64'h304, 32'h304, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", 64'(b.out_valid), 64'h0);
    chk("arst_occupancy", 64'(b.occupancy), 64'h0);
    chk("arst_out_instr", 64'(b.out_instr), 64'(NOP));
    chk("arst_out_pc", b.out_pc, 64'h0);
    chk("arst_stall_cnt", 64'(b.stall_cnt), 64'h0);
    chk("arst_flush_cnt", 64'(b.flush_cnt), 64'h0);
    q.delete(); e_stall = 0; e_flush = 0;
    @(negedge clk);
    rst_n = 1;
    step(1, 64'h400, 32'h400, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // 4-bit counter saturation on the second instance
    @(negedge clk);
    bs.in_valid = 1; bs.in_pc = 64'h500; bs.in_instr = 32'h500;
    @(negedge clk);
    bs.in_valid = 0;
    repeat (20) @(negedge clk);
    chk("sat_stall_20", 64'(bs.stall_cnt), 64'd15);
    chk("sat_out_valid", 64'(bs.out_valid), 64'h1);
    repeat (5) @(negedge clk);
    chk("sat_stall_25", 64'(bs.stall_cnt), 64'd15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF/ID pipeline stage: carries PC and instruction from fetch to decode through a two-entry skid buffer with a valid/ready handshake, synchronous flush with NOP injection, and saturating stall/flush performance counters. It sits between the instruction-memory output and the decoder and replaces the fixed-width, non-stallable IF/ID register. It supports full-throughput streaming, back-pressure from decode, and branch-redirect squashing.

## Interface

Parameters:
- ADDR_W, 64, PC width.
- INSTR_W, 32, instruction width.
- NOP_INSTR, 32'h00000013 (addi x0,x0,0), value driven on out_instr when no valid entry; width INSTR_W.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a valid PC/instruction pair.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  ADDR_W  fetched PC.
- in_instr  in  INSTR_W  fetched instruction.
- flush  in  1  synchronous squash of all held entries.
- out_valid  out  1  out_pc/out_instr hold a valid entry.
- out_ready  in  1  decode consumes the entry this cycle.
- out_pc  out  ADDR_W  PC of the head entry.
- out_instr  out  INSTR_W  instruction of the head entry.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_cnt  out  CNT_W  cycles with flush=1.

## Operation

- Storage: a head entry (main) and a skid entry, each holding {pc, instr}. Entries leave in strict arrival order.
- accept = in_valid & in_ready. take = out_valid & out_ready.
- in_ready = (state != FULL) & ~flush. This is combinational, so an input offered during a flush cycle is never accepted.
- out_valid = (state != EMPTY). out_pc/out_instr come straight from the main registers, with no combinational path from the inputs.
- States and transitions (flush=0):
  - EMPTY: accept -> ONE, main <= input.
  - ONE: accept & take -> ONE, main <= input. accept & ~take -> FULL, skid <= input. take & ~accept -> EMPTY. Otherwise hold.
  - FULL: take -> ONE, main <= skid. Otherwise hold. No accept is possible.
- flush=1 overrides everything in the same edge. Next state is EMPTY, main.pc <= 0, main.instr <= NOP_INSTR, and the skid is cleared. A take in the flush cycle still completes, because decode already sampled the outputs.
- Whenever the state is EMPTY, the main registers hold pc=0 and instr=NOP_INSTR. A take to EMPTY loads these values.
- occupancy encodes the state: EMPTY=0, ONE=1, FULL=2.
- stall_cnt increments on every edge where out_valid & ~out_ready. flush_cnt increments on every edge where flush=1. Both saturate at 2^CNT_W-1 and never wrap.

## Timing

- Reset asserted (reset=0), effective immediately without a clock:
  - state EMPTY, so out_valid=0, occupancy=0, in_ready=1 (when flush=0).
  - out_pc=0, out_instr=NOP_INSTR.
  - skid cleared, stall_cnt=0, flush_cnt=0.
- Reset asserted mid-operation discards all entries. No partial entry survives.
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N.
- Throughput: one entry per cycle when out_ready is held at 1. The skid is never used in that case.
- in_ready drops the cycle after the skid fills, and rises the cycle after a take from FULL. The skid absorbs the one in-flight beat, so no beat is lost or duplicated.
- Simultaneous accept and take in ONE: the head is replaced in place and occupancy stays 1.
- Simultaneous flush and in_valid: the input is dropped and in_ready=0 in that cycle.
- A counter at saturation stays at its maximum on further qualifying cycles.

## Test plan

- Reset then stream: release reset, hold out_ready=1, and send PC 0x0,0x4,0x8 with instr 0xA,0xB,0xC on consecutive cycles -> outputs appear one cycle later in order, occupancy stays ≤1, in_ready is always 1, stall_cnt=0.
- Back-pressure fill: with out_ready=0, send PC 0x100 then 0x104 -> occupancy reaches 2, in_ready=0, and a third beat 0x108 is held off. Raise out_ready -> consumed order is 0x100, 0x104, 0x108, with stall_cnt equal to the number of stalled cycles.
- Flush at FULL: with entries 0x200 and 0x204 held and in_valid=1 for 0x208, assert flush for one cycle -> next cycle out_valid=0, out_pc=0, out_instr=0x00000013, occupancy=0, flush_cnt=1, and 0x208 is never emitted.
- Async reset mid-stream: with occupancy=2, pull reset low between clock edges -> out_valid=0, out_instr=NOP_INSTR, and the counters read 0 immediately, before the next edge.
- Counter saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reads 15 and stays at 15.
- Randomised valid/ready/flush for 10k cycles against a reference queue model -> no loss, duplication or reordering of non-flushed entries.
